// File: rtl/clock_enable_gen_if.sv
// Signal bundle for clock_enable_gen: the mode request (plus the optional
// CPU stall input) and every enable/counter output.
// Optional feature macro: CLOCK_STALL_EN adds the wait_n signal.
interface clock_enable_gen_if #(
    parameter int DIV_BITS  = 3,
    parameter int MODE_BITS = 2
);
    logic [MODE_BITS-1:0] mode;
`ifdef CLOCK_STALL_EN
    logic                 wait_n;
`endif
    logic [DIV_BITS-1:0]  count;
    logic [DIV_BITS-1:0]  ce_p;
    logic [DIV_BITS-1:0]  ce_n;
    logic                 cpu_ce_p;
    logic                 cpu_ce_n;
    logic [MODE_BITS-1:0] active_mode;

`ifdef CLOCK_STALL_EN
    modport master (
        output mode, wait_n,
        input  count, ce_p, ce_n, cpu_ce_p, cpu_ce_n, active_mode
    );
    modport slave (
        input  mode, wait_n,
        output count, ce_p, ce_n, cpu_ce_p, cpu_ce_n, active_mode
    );
`else
    modport master (
        output mode,
        input  count, ce_p, ce_n, cpu_ce_p, cpu_ce_n, active_mode
    );
    modport slave (
        input  mode,
        output count, ce_p, ce_n, cpu_ce_p, cpu_ce_n, active_mode
    );
`endif
endinterface

// File: rtl/clock_enable_gen.sv
// Clock-enable generator: free-running divider counter on the master clock
// with rising/falling phase enables per tap, plus a CPU enable pair whose
// rate (turbo mode) only changes at the wrap of the slowest period.
// Optional feature macro: CLOCK_STALL_EN (wait_n stalls the CPU enables).
module clock_enable_gen #(
    parameter int DIV_BITS  = 3,
    parameter int MODE_BITS = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    clock_enable_gen_if.slave bus
);
    logic [DIV_BITS-1:0]  r_count;
    logic [DIV_BITS-1:0]  r_ce_p;
    logic [DIV_BITS-1:0]  r_ce_n;
    logic                 r_cpu_ce_p;
    logic                 r_cpu_ce_n;
    logic [MODE_BITS-1:0] r_active_mode;

    logic [DIV_BITS-1:0]  w_count_next;
    logic [DIV_BITS-1:0]  w_ce_p_next;
    logic [DIV_BITS-1:0]  w_ce_n_next;
    logic                 w_wrap;
    logic [MODE_BITS-1:0] w_mode_next;
    logic                 w_cpu_p_next;
    logic                 w_cpu_n_next;
    logic                 w_run;

    // Next count and the per-tap phase decode of that value, so the
    // registered pulses line up with the count shown on the output.
    always_comb begin
        logic [DIV_BITS-1:0] v_low;
        v_low        = '0;
        w_count_next = r_count + DIV_BITS'(1);
        w_ce_p_next  = '0;
        w_ce_n_next  = '0;
        for (int k = 0; k < DIV_BITS; k++) begin
            v_low          = DIV_BITS'((1 << k) - 1);
            w_ce_p_next[k] =  w_count_next[k] & ((w_count_next & v_low) == '0);
            w_ce_n_next[k] = ~w_count_next[k] & ((w_count_next & v_low) == '0);
        end
    end

    // Mode is adopted only at wrap, where every tap's ce_n fires together,
    // so switching taps there never shortens a CPU cycle.
    always_comb begin
        int v_eff;
        int v_sel;
        w_wrap       = (w_count_next == '0);
        w_mode_next  = w_wrap ? bus.mode : r_active_mode;
        v_eff        = int'(w_mode_next);
        if (v_eff > DIV_BITS - 1) begin
            v_eff = DIV_BITS - 1;
        end
        v_sel        = DIV_BITS - 1 - v_eff;
        w_cpu_p_next = 1'b0;
        w_cpu_n_next = 1'b0;
        for (int k = 0; k < DIV_BITS; k++) begin
            if (k == v_sel) begin
                w_cpu_p_next = w_ce_p_next[k];
                w_cpu_n_next = w_ce_n_next[k];
            end
        end
    end

    // Stall gate. Folding wait_n into the cpu_ce registers on the same edge
    // that a separate wait_q flop would sample it gives identical timing:
    // suppression starts one cycle after the fall and ends one after the rise.
`ifdef CLOCK_STALL_EN
    always_comb begin
        w_run = bus.wait_n;
    end
`else
    always_comb begin
        w_run = 1'b1;
    end
`endif

    // All outputs registered; async reset discards any pending mode request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count       <= '0;
            r_ce_p        <= '0;
            r_ce_n        <= '0;
            r_cpu_ce_p    <= 1'b0;
            r_cpu_ce_n    <= 1'b0;
            r_active_mode <= '0;
        end else begin
            r_count       <= w_count_next;
            r_ce_p        <= w_ce_p_next;
            r_ce_n        <= w_ce_n_next;
            r_cpu_ce_p    <= w_cpu_p_next & w_run;
            r_cpu_ce_n    <= w_cpu_n_next & w_run;
            r_active_mode <= w_mode_next;
        end
    end

    assign bus.count       = r_count;
    assign bus.ce_p        = r_ce_p;
    assign bus.ce_n        = r_ce_n;
    assign bus.cpu_ce_p    = r_cpu_ce_p;
    assign bus.cpu_ce_n    = r_cpu_ce_n;
    assign bus.active_mode = r_active_mode;
endmodule

// File: tb/tb_clock_enable_gen.sv
// Self-checking bench for clock_enable_gen (DIV_BITS=3, MODE_BITS=2).
// Optional feature macro: CLOCK_STALL_EN enables the stall section.
module tb_clock_enable_gen;
    localparam int D  = 3;
    localparam int MB = 2;

    logic clock;
    logic reset_n;

    clock_enable_gen_if #(.DIV_BITS(D), .MODE_BITS(MB)) bus ();

    clock_enable_gen #(.DIV_BITS(D), .MODE_BITS(MB)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: edges since reset release, applied mode, stall.
    int unsigned m_n;
    int          m_am;
    int          m_wait;
    int          m_in_reset;

    typedef struct {
        logic [1:0] mode;
        int         cnt;
        logic [2:0] cep;
        logic [2:0] cen;
        int         am;
        logic       cp;
        logic       cn;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int          c;
        int          per;
        int          eff;
        int          div;
        logic [2:0]  ep;
        logic [2:0]  en;
        logic        ecp;
        logic        ecn;
        c  = int'(m_n % (2 ** D));
        ep = '0;
        en = '0;
        for (int k = 0; k < D; k++) begin
            per   = 2 ** (k + 1);
            ep[k] = ((c % per) == per / 2);
            en[k] = ((c % per) == 0);
        end
        eff = (m_am > D - 1) ? D - 1 : m_am;
        div = 2 ** (D - eff);
        ecp = ((c % div) == div / 2) && (m_wait != 0);
        ecn = ((c % div) == 0) && (m_wait != 0);
        if (m_in_reset != 0) begin
            c = 0; ep = '0; en = '0; ecp = 1'b0; ecn = 1'b0;
        end
        chk("count",       32'(bus.count),       32'(c));
        chk("ce_p",        32'(bus.ce_p),        32'(ep));
        chk("ce_n",        32'(bus.ce_n),        32'(en));
        chk("cpu_ce_p",    32'(bus.cpu_ce_p),    32'(ecp));
        chk("cpu_ce_n",    32'(bus.cpu_ce_n),    32'(ecn));
        chk("active_mode", 32'(bus.active_mode), (m_in_reset != 0) ? 32'd0 : 32'(m_am));
    endtask

    // Drive inputs, take one edge, advance the model, check #1 later.
    task automatic step(input logic [1:0] md, input logic wt);
        bus.mode = md;
`ifdef CLOCK_STALL_EN
        bus.wait_n = wt;
`endif
        @(posedge clock);
        if (reset_n) begin
            m_n++;
            if ((m_n % (2 ** D)) == 0) m_am = int'(md);
`ifdef CLOCK_STALL_EN
            m_wait = int'(wt);
`else
            m_wait = (wt === 1'bx) ? 1 : 1;
`endif
        end
        #1;
        check_all();
    endtask

    task automatic release_reset();
        reset_n    = 1'b1;
        m_in_reset = 0;
        m_n        = 0;
        m_am       = 0;
        m_wait     = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[16];
        int   cnt_p2;
        int   cnt_n2;
        int   cnt_eq;
        int   found;
        int   cpu_seen;

        tbl[0]  = '{2'd0, 1, 3'b001, 3'b000, 0, 1'b0, 1'b0};
        tbl[1]  = '{2'd0, 2, 3'b010, 3'b001, 0, 1'b0, 1'b0};
        tbl[2]  = '{2'd0, 3, 3'b001, 3'b000, 0, 1'b0, 1'b0};
        tbl[3]  = '{2'd0, 4, 3'b100, 3'b011, 0, 1'b1, 1'b0};
        tbl[4]  = '{2'd0, 5, 3'b001, 3'b000, 0, 1'b0, 1'b0};
        tbl[5]  = '{2'd1, 6, 3'b010, 3'b001, 0, 1'b0, 1'b0};
        tbl[6]  = '{2'd1, 7, 3'b001, 3'b000, 0, 1'b0, 1'b0};
        tbl[7]  = '{2'd1, 0, 3'b000, 3'b111, 1, 1'b0, 1'b1};
        tbl[8]  = '{2'd1, 1, 3'b001, 3'b000, 1, 1'b0, 1'b0};
        tbl[9]  = '{2'd1, 2, 3'b010, 3'b001, 1, 1'b1, 1'b0};
        tbl[10] = '{2'd1, 3, 3'b001, 3'b000, 1, 1'b0, 1'b0};
        tbl[11] = '{2'd1, 4, 3'b100, 3'b011, 1, 1'b0, 1'b1};
        tbl[12] = '{2'd1, 5, 3'b001, 3'b000, 1, 1'b0, 1'b0};
        tbl[13] = '{2'd1, 6, 3'b010, 3'b001, 1, 1'b1, 1'b0};
        tbl[14] = '{2'd1, 7, 3'b001, 3'b000, 1, 1'b0, 1'b0};
        tbl[15] = '{2'd1, 0, 3'b000, 3'b111, 1, 1'b0, 1'b1};

        // Reset held 5 cycles with a non-zero mode request.
        reset_n    = 1'b0;
        m_in_reset = 1;
        m_n        = 0;
        m_am       = 0;
        m_wait     = 1;
        bus.mode   = 2'd2;
`ifdef CLOCK_STALL_EN
        bus.wait_n = 1'b1;
`endif
        repeat (5) step(2'd2, 1'b1);

        // Release, then the deferred 0->1 switch table from the first edge.
        release_reset();
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].mode, 1'b1);
            chk($sformatf("tbl%0d.count", i), 32'(bus.count),       32'(tbl[i].cnt));
            chk($sformatf("tbl%0d.ce_p", i),  32'(bus.ce_p),        32'(tbl[i].cep));
            chk($sformatf("tbl%0d.ce_n", i),  32'(bus.ce_n),        32'(tbl[i].cen));
            chk($sformatf("tbl%0d.am", i),    32'(bus.active_mode), 32'(tbl[i].am));
            chk($sformatf("tbl%0d.cpu_p", i), 32'(bus.cpu_ce_p),    32'(tbl[i].cp));
            chk($sformatf("tbl%0d.cpu_n", i), 32'(bus.cpu_ce_n),    32'(tbl[i].cn));
        end

        // Back to mode 0 at next wrap, then 64 cycles of tap-period counting.
        repeat (8) step(2'd0, 1'b1);
        chk("am_back_to_0", 32'(bus.active_mode), 32'd0);
        cnt_p2 = 0; cnt_n2 = 0; cnt_eq = 0;
        for (int i = 0; i < 64; i++) begin
            step(2'd0, 1'b1);
            if (bus.ce_p[2]) cnt_p2++;
            if (bus.ce_n[2]) cnt_n2++;
            if (bus.cpu_ce_p == bus.ce_p[2]) cnt_eq++;
        end
        chk("ce_p2_pulses", 32'(cnt_p2), 32'd8);
        chk("ce_n2_pulses", 32'(cnt_n2), 32'd8);
        chk("cpu_eq_ce_p2", 32'(cnt_eq), 32'd64);

        // Saturation at mode 3, then a 3->0->3 blip between wraps.
        repeat (8) step(2'd3, 1'b1);
        chk("am_sat", 32'(bus.active_mode), 32'd3);
        step(2'd3, 1'b1);
        step(2'd3, 1'b1);
        step(2'd0, 1'b1);
        repeat (5) step(2'd3, 1'b1);
        chk("am_revert_count", 32'(bus.count), 32'd0);
        chk("am_revert", 32'(bus.active_mode), 32'd3);
        cpu_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step(2'd3, 1'b1);
            if (bus.cpu_ce_p) cpu_seen++;
        end
        chk("sat_cpu_p_count", 32'(cpu_seen), 32'd4);

        // Randomized mode requests against the model.
        for (int i = 0; i < 400; i++) begin
            step(2'($urandom_range(0, 3)), 1'b1);
        end

`ifdef CLOCK_STALL_EN
        // Stall: mode 1, wait_n low for 10 cycles.
        repeat (16) step(2'd1, 1'b1);
        cpu_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step(2'd1, 1'b0);
            if (bus.cpu_ce_p || bus.cpu_ce_n) cpu_seen++;
        end
        chk("stall_cpu_quiet", 32'(cpu_seen), 32'd0);
        repeat (8) step(2'd1, 1'b1);
        for (int i = 0; i < 200; i++) begin
            step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        repeat (2) step(2'd1, 1'b1);
`endif

        // Async reset between edges at count=6.
        found = 0;
        for (int i = 0; i < 16 && found == 0; i++) begin
            step(2'd1, 1'b1);
            if (bus.count == 3'd6) found = 1;
        end
        chk("found_count6", 32'(found), 32'd1);
        #2;
        reset_n    = 1'b0;
        m_in_reset = 1;
        #1;
        check_all();
        repeat (3) step(2'd2, 1'b1);
        release_reset();
        step(2'd0, 1'b1);
        chk("rst2_count1", 32'(bus.count), 32'd1);
        chk("rst2_ce_p",   32'(bus.ce_p),  32'd1);
        chk("rst2_ce_n",   32'(bus.ce_n),  32'd0);
        for (int i = 0; i < 9; i++) step(2'd0, 1'b1);
        chk("rst2_count_after", 32'(bus.count), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
